// File: rtl/updown_count_monitor.sv
// Health monitor for an up/down counter: classifies each count step, flags
// wraps, direction changes and illegal or mode-inconsistent steps.
module updown_count_monitor #(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              err_clr_i,
  output logic              wrap_up_o,
  output logic              wrap_dn_o,
  output logic              dir_chg_o,
  output logic [WRAP_W-1:0] wrap_cnt_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    prev_q, prev_d;
  logic                mode_q, mode_d;
  logic                last_dir_q, last_dir_d;
  logic                last_dir_vld_q, last_dir_vld_d;
  logic                wrap_up_q, wrap_up_d;
  logic                wrap_dn_q, wrap_dn_d;
  logic                dir_chg_q, dir_chg_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                err_q, err_d;

  logic [CNT_W-1:0]    prev_inc, prev_dec;
  logic                step_up, step_dn, err_evt;

  // State register and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_INIT;
      prev_q         <= '0;
      mode_q         <= 1'b0;
      last_dir_q     <= 1'b0;
      last_dir_vld_q <= 1'b0;
      wrap_up_q      <= 1'b0;
      wrap_dn_q      <= 1'b0;
      dir_chg_q      <= 1'b0;
      wrap_cnt_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      mode_q         <= mode_d;
      last_dir_q     <= last_dir_d;
      last_dir_vld_q <= last_dir_vld_d;
      wrap_up_q      <= wrap_up_d;
      wrap_dn_q      <= wrap_dn_d;
      dir_chg_q      <= dir_chg_d;
      wrap_cnt_q     <= wrap_cnt_d;
      err_q          <= err_d;
    end
  end

  // Step classification, next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    mode_d         = mode_q;
    last_dir_d     = last_dir_q;
    last_dir_vld_d = last_dir_vld_q;
    wrap_up_d      = 1'b0;
    wrap_dn_d      = 1'b0;
    dir_chg_d      = 1'b0;
    wrap_cnt_d     = wrap_cnt_q;
    err_d          = err_q;
    step_up        = 1'b0;
    step_dn        = 1'b0;
    err_evt        = 1'b0;
    prev_inc       = prev_q + CNT_W'(1);
    prev_dec       = prev_q - CNT_W'(1);

    case (state_q)
      ST_INIT: begin
        prev_d  = count_i;
        mode_d  = mode_i;
        state_d = ST_TRACK;
      end
      ST_TRACK: begin
        prev_d = count_i;
        mode_d = mode_i;
        if (count_i != prev_q) begin
          // With a 1-bit count +1 and -1 coincide; mode decides the direction
          if (count_i == prev_inc && count_i == prev_dec) begin
            step_up = mode_q;
            step_dn = !mode_q;
          end else if (count_i == prev_inc) begin
            step_up = 1'b1;
          end else if (count_i == prev_dec) begin
            step_dn = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
        end
        if ((step_up && !mode_q) || (step_dn && mode_q)) begin
          err_evt = 1'b1;
        end
        if (step_up || step_dn) begin
          wrap_up_d      = step_up && (prev_q == CNT_MAX);
          wrap_dn_d      = step_dn && (prev_q == '0);
          dir_chg_d      = last_dir_vld_q && (last_dir_q != step_up);
          last_dir_d     = step_up;
          last_dir_vld_d = 1'b1;
        end
        if ((wrap_up_d || wrap_dn_d) && (wrap_cnt_q != WRAP_MAX)) begin
          wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A new error on the clearing edge wins
    if (err_clr_i) err_d = 1'b0;
    if (err_evt)   err_d = 1'b1;
  end

  assign wrap_up_o  = wrap_up_q;
  assign wrap_dn_o  = wrap_dn_q;
  assign dir_chg_o  = dir_chg_q;
  assign wrap_cnt_o = wrap_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Bench for updown_count_monitor: directed vector table, hand-written corner
// sequences and randomized steps checked against an arithmetic reference model.
module tb_updown_count_monitor;

  logic       clk = 1'b0;
  logic       rst_i, mode_i, err_clr_i;
  logic [2:0] count_i;
  logic       wrap_up_o, wrap_dn_o, dir_chg_o, err_o;
  logic [7:0] wrap_cnt_o;
  logic       w2_wrap_up, w2_wrap_dn, w2_dir_chg, w2_err;
  logic [1:0] w2_wrap_cnt;

  always #5 clk = ~clk;

  updown_count_monitor #(.CNT_W(3), .WRAP_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .count_i(count_i),
    .err_clr_i(err_clr_i), .wrap_up_o(wrap_up_o), .wrap_dn_o(wrap_dn_o),
    .dir_chg_o(dir_chg_o), .wrap_cnt_o(wrap_cnt_o), .err_o(err_o)
  );

  // Same stimulus, narrow tally to exercise saturation
  updown_count_monitor #(.CNT_W(3), .WRAP_W(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .count_i(count_i),
    .err_clr_i(err_clr_i), .wrap_up_o(w2_wrap_up), .wrap_dn_o(w2_wrap_dn),
    .dir_chg_o(w2_dir_chg), .wrap_cnt_o(w2_wrap_cnt), .err_o(w2_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: step size computed modulo 8 from raw integers
  int m_prev, m_mode, m_last, m_tally;
  bit m_init, m_wu, m_wd, m_dc, m_err;

  task automatic model_edge(input logic r, input logic m, input logic [2:0] c, input logic cl);
    int d, dir;
    bit e;
    if (r) begin
      m_prev = 0; m_mode = 0; m_last = -1; m_tally = 0; m_init = 1;
      m_wu = 0; m_wd = 0; m_dc = 0; m_err = 0;
      return;
    end
    m_wu = 0; m_wd = 0; m_dc = 0; e = 0; dir = -1;
    if (!m_init) begin
      d = ((int'(c) - m_prev) % 8 + 8) % 8;
      if (d == 1) dir = 1;
      else if (d == 7) dir = 0;
      else if (d != 0) e = 1;
      if (dir >= 0) begin
        if (dir != m_mode) e = 1;
        m_wu = (dir == 1) && (m_prev == 7);
        m_wd = (dir == 0) && (m_prev == 0);
        m_dc = (m_last >= 0) && (m_last != dir);
        m_last = dir;
        if (m_wu || m_wd) m_tally++;
      end
    end
    m_init = 0;
    if (cl) m_err = 0;
    if (e) m_err = 1;
    m_prev = int'(c);
    m_mode = int'(m);
  endtask

  task automatic step(input logic r, input logic m, input logic [2:0] c, input logic cl);
    rst_i = r; mode_i = m; count_i = c; err_clr_i = cl;
    @(posedge clk);
    model_edge(r, m, c, cl);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".wrap_up"}, int'(wrap_up_o), int'(m_wu));
    chk({tag, ".wrap_dn"}, int'(wrap_dn_o), int'(m_wd));
    chk({tag, ".dir_chg"}, int'(dir_chg_o), int'(m_dc));
    chk({tag, ".err"},     int'(err_o),     int'(m_err));
    chk({tag, ".wrap_cnt"},    int'(wrap_cnt_o),  (m_tally > 255) ? 255 : m_tally);
    chk({tag, ".wrap_cnt_w2"}, int'(w2_wrap_cnt), (m_tally > 3) ? 3 : m_tally);
  endtask

  typedef struct {
    logic       rst, mode, clr;
    logic [2:0] cnt;
    logic       wu, wd, dc, err;
    int         wc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input int c, input logic cl,
                     input logic wu, input logic wd, input logic dc, input logic er,
                     input int wc);
    vec_t v;
    v.rst = r; v.mode = m; v.cnt = 3'(c); v.clr = cl;
    v.wu = wu; v.wd = wd; v.dc = dc; v.err = er; v.wc = wc;
    vecs.push_back(v);
  endtask

  initial begin
    logic [2:0] cur;
    logic       last_mode, m, r, cl;
    int         sel;

    rst_i = 1'b1; mode_i = 1'b0; count_i = '0; err_clr_i = 1'b0;

    // Reset, then up run with one up-wrap
    add(1,0,0,0, 0,0,0,0, 0);
    add(1,0,0,0, 0,0,0,0, 0);
    for (int i = 0; i < 8; i++) add(0,1,i,0, 0,0,0,0, 0);
    add(0,1,0,0, 1,0,0,0, 1);
    add(0,1,1,0, 0,0,0,0, 1);
    // Down run: direction change then down-wrap
    add(0,0,2,0, 0,0,0,0, 1);
    add(0,0,1,0, 0,0,1,0, 1);
    add(0,0,0,0, 0,0,0,0, 1);
    add(0,0,7,0, 0,1,0,0, 2);
    for (int i = 6; i >= 1; i--) add(0,0,i,0, 0,0,0,0, 2);
    // Illegal jump 2->5, sticky until cleared
    add(0,1,1,0, 0,0,0,0, 2);
    add(0,1,2,0, 0,0,1,0, 2);
    add(0,1,5,0, 0,0,0,1, 2);
    add(0,1,6,0, 0,0,0,1, 2);
    add(0,1,7,1, 0,0,0,0, 2);
    add(0,1,7,0, 0,0,0,0, 2);
    // Clear coinciding with a jump, then up step against down mode
    add(0,0,3,1, 0,0,0,1, 2);
    add(0,0,3,1, 0,0,0,0, 2);
    add(0,0,4,0, 0,0,0,1, 2);
    add(0,1,4,1, 0,0,0,0, 2);
    // Holds produce nothing; direction change only on 7->6
    add(0,1,5,0, 0,0,0,0, 2);
    add(0,1,6,0, 0,0,0,0, 2);
    for (int i = 0; i < 5; i++) add(0,1,6,0, 0,0,0,0, 2);
    add(0,0,7,0, 0,0,0,0, 2);
    add(0,0,6,0, 0,0,1,0, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].cnt, vecs[i].clr);
      chk($sformatf("vec%0d.wrap_up", i),  int'(wrap_up_o),  int'(vecs[i].wu));
      chk($sformatf("vec%0d.wrap_dn", i),  int'(wrap_dn_o),  int'(vecs[i].wd));
      chk($sformatf("vec%0d.dir_chg", i),  int'(dir_chg_o),  int'(vecs[i].dc));
      chk($sformatf("vec%0d.err", i),      int'(err_o),      int'(vecs[i].err));
      chk($sformatf("vec%0d.wrap_cnt", i), int'(wrap_cnt_o), vecs[i].wc);
      chk($sformatf("vec%0d.wrap_cnt_w2", i), int'(w2_wrap_cnt), (vecs[i].wc > 3) ? 3 : vecs[i].wc);
    end

    // Five up-wraps: narrow tally saturates at 3
    step(1,0,0,0);
    step(1,0,0,0);
    for (int c = 0; c <= 44; c++) begin
      step(0,1,3'(c),0);
      chk_model("sat");
    end
    chk("sat.final_w8", int'(wrap_cnt_o), 5);
    chk("sat.final_w2", int'(w2_wrap_cnt), 3);

    // Reset mid-count at 4, then a discontinuous first sample
    step(1,1,4,0);
    chk("midrst.wrap_cnt", int'(wrap_cnt_o), 0);
    chk("midrst.wrap_cnt_w2", int'(w2_wrap_cnt), 0);
    chk("midrst.outs", int'({wrap_up_o, wrap_dn_o, dir_chg_o, err_o}), 0);
    step(0,1,6,0);
    chk("postrst.err0", int'(err_o), 0);
    step(0,1,7,0);
    chk("postrst.err1", int'(err_o), 0);
    chk("postrst.dir_chg", int'(dir_chg_o), 0);

    // Randomized steps, mostly following mode with occasional faults
    cur = 3'd7; last_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      m   = ($urandom_range(0, 3) == 0) ? ~last_mode : last_mode;
      cl  = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 19);
      if (sel == 0)      cur = 3'($urandom_range(0, 7));
      else if (sel < 4)  cur = cur;
      else if (sel == 4) cur = last_mode ? cur - 3'd1 : cur + 3'd1;
      else               cur = last_mode ? cur + 3'd1 : cur - 3'd1;
      step(r, m, cur, cl);
      chk_model($sformatf("rnd%0d", i));
      last_mode = m;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
